// File: rtl/wb_port_arbiter.sv
// Writeback-stage arbiter that owns the single register-file write port.
// ALU results always win. Load returns are buffered in a small FIFO.
// A winning ALU write kills any older buffered load to the same register,
// which keeps write-after-write order correct. A starvation counter raises
// AluHold so that a live load at the FIFO head eventually drains.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     Clock,
  input  logic                     NReset,
  input  logic                     AluValid,
  input  logic [4:0]               AluRegID,
  input  logic [31:0]              AluData,
  input  logic                     MemValid,
  output logic                     MemReady,
  input  logic [4:0]               MemRegID,
  input  logic [31:0]              MemData,
  output logic [31:0]              WriteData,
  output logic [4:0]               WriteRegID,
  output logic                     WriteEnable,
  output logic                     AluHold,
  output logic [31:0]              PendingMask,
  output logic [$clog2(DEPTH):0]   FifoCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // FIFO storage and bookkeeping
  logic          live_r  [DEPTH];
  logic [4:0]    regid_r [DEPTH];
  logic [31:0]   data_r  [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  // Starvation tracking
  logic [SW-1:0] starve_r;
  logic          popped_r;
  logic          hold_r;

  // Registered write port and hazard mask
  logic [31:0]   wdata_r;
  logic [4:0]    wid_r;
  logic          we_r;
  logic [31:0]   pending_r;

  // Combinational decisions
  logic          empty_s;
  logic          alu_win_s;
  logic          head_live_s;
  logic          pop_s;
  logic          mem_ready_s;
  logic          push_s;
  logic          push_live_s;
  logic          live_nxt_s  [DEPTH];
  logic [4:0]    regid_nxt_s [DEPTH];
  logic [31:0]   pending_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic [SW-1:0] starve_nxt_s;
  logic          hold_nxt_s;
  logic [31:0]   wdata_nxt_s;
  logic [4:0]    wid_nxt_s;
  logic          we_nxt_s;

  assign empty_s     = (count_r == {CW{1'b0}});
  assign alu_win_s   = AluValid && (AluRegID != 5'd0);
  assign head_live_s = live_r[rd_ptr_r] && !empty_s;
  assign pop_s       = !alu_win_s && !empty_s;
  assign mem_ready_s = (count_r < CW'(DEPTH));
  // A zero destination completes the handshake but is never stored.
  assign push_s      = MemValid && mem_ready_s && (MemRegID != 5'd0);
  assign push_live_s = !(alu_win_s && (AluRegID == MemRegID));
  assign count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);

  // Next live flags and destinations: apply WAW kills, pop clear, and push.
  always_comb begin
    pending_nxt_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      // The push slot is always a free (non-live) slot, so it can simply override.
      live_nxt_s[i]  = (push_s && (wr_ptr_r == AW'(i))) ? push_live_s :
                       (live_r[i]
                        && !(alu_win_s && (regid_r[i] == AluRegID))
                        && !(pop_s && (rd_ptr_r == AW'(i))));
      regid_nxt_s[i] = (push_s && (wr_ptr_r == AW'(i))) ? MemRegID : regid_r[i];
      pending_nxt_s  = pending_nxt_s |
                       (live_nxt_s[i] ? (32'd1 << regid_nxt_s[i]) : 32'd0);
    end
  end

  // Starvation counter and hold request.
  always_comb begin
    starve_nxt_s = starve_r;
    if (alu_win_s && head_live_s) begin
      starve_nxt_s = (starve_r == STARVE_MAX) ? starve_r : (starve_r + {{(SW-1){1'b0}}, 1'b1});
    end else if (pop_s || empty_s) begin
      starve_nxt_s = {SW{1'b0}};
    end else begin
      starve_nxt_s = starve_r;
    end
    // Hold drops on the edge after the pop that relieved the head.
    if (hold_r) begin
      hold_nxt_s = !popped_r;
    end else begin
      hold_nxt_s = (starve_nxt_s >= STARVE_MAX);
    end
  end

  // Write-port selection: ALU first, then the FIFO head. A killed head consumes the cycle.
  always_comb begin
    wdata_nxt_s = wdata_r;
    wid_nxt_s   = wid_r;
    we_nxt_s    = 1'b0;
    if (alu_win_s) begin
      wdata_nxt_s = AluData;
      wid_nxt_s   = AluRegID;
      we_nxt_s    = 1'b1;
    end else if (pop_s && head_live_s) begin
      wdata_nxt_s = data_r[rd_ptr_r];
      wid_nxt_s   = regid_r[rd_ptr_r];
      we_nxt_s    = 1'b1;
    end else begin
      we_nxt_s    = 1'b0;
    end
  end

  // State register: FIFO, counters and registered outputs, synchronous reset.
  always_ff @(posedge Clock) begin
    if (!NReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        live_r[i]  <= 1'b0;
        regid_r[i] <= 5'd0;
        data_r[i]  <= 32'd0;
      end
      rd_ptr_r  <= {AW{1'b0}};
      wr_ptr_r  <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      starve_r  <= {SW{1'b0}};
      popped_r  <= 1'b0;
      hold_r    <= 1'b0;
      wdata_r   <= 32'd0;
      wid_r     <= 5'd0;
      we_r      <= 1'b0;
      pending_r <= 32'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        live_r[i]  <= live_nxt_s[i];
        regid_r[i] <= regid_nxt_s[i];
        if (push_s && (wr_ptr_r == AW'(i))) begin
          data_r[i] <= MemData;
        end
      end
      rd_ptr_r  <= rd_ptr_r + AW'(pop_s);
      wr_ptr_r  <= wr_ptr_r + AW'(push_s);
      count_r   <= count_nxt_s;
      starve_r  <= starve_nxt_s;
      popped_r  <= pop_s;
      hold_r    <= hold_nxt_s;
      wdata_r   <= wdata_nxt_s;
      wid_r     <= wid_nxt_s;
      we_r      <= we_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  assign MemReady    = mem_ready_s;
  assign WriteData   = wdata_r;
  assign WriteRegID  = wid_r;
  assign WriteEnable = we_r;
  assign AluHold     = hold_r;
  assign PendingMask = pending_r;
  assign FifoCount   = count_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: queue-based reference model plus literal checks.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int LIM   = 3;

  logic        Clock;
  logic        NReset;
  logic        AluValid;
  logic [4:0]  AluRegID;
  logic [31:0] AluData;
  logic        MemValid;
  logic        MemReady;
  logic [4:0]  MemRegID;
  logic [31:0] MemData;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegID;
  logic        WriteEnable;
  logic        AluHold;
  logic [31:0] PendingMask;
  logic [2:0]  FifoCount;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .Clock(Clock), .NReset(NReset),
    .AluValid(AluValid), .AluRegID(AluRegID), .AluData(AluData),
    .MemValid(MemValid), .MemReady(MemReady), .MemRegID(MemRegID), .MemData(MemData),
    .WriteData(WriteData), .WriteRegID(WriteRegID), .WriteEnable(WriteEnable),
    .AluHold(AluHold), .PendingMask(PendingMask), .FifoCount(FifoCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit        live;
    bit [4:0]  rid;
    bit [31:0] d;
  } ent_t;

  // Reference model state (post-edge view)
  ent_t      q[$];
  bit [31:0] m_wd;
  bit [4:0]  m_wid;
  bit        m_we;
  bit        m_hold;
  int        m_starve;
  bit        m_popped_last;

  logic [31:0] shadow [32];
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input bit nrst, input bit av, input bit [4:0] aid, input bit [31:0] ad,
                            input bit mv, input bit [4:0] mid, input bit [31:0] md);
    bit win, nonempty, head_live, acc, pop;
    ent_t e;
    if (!nrst) begin
      q.delete();
      m_wd = 32'd0; m_wid = 5'd0; m_we = 1'b0; m_hold = 1'b0;
      m_starve = 0; m_popped_last = 1'b0;
      return;
    end
    win       = av && (aid != 5'd0);
    nonempty  = (q.size() > 0);
    head_live = nonempty && q[0].live;
    acc       = mv && (q.size() < DEPTH);
    pop       = !win && nonempty;
    if (win) begin
      foreach (q[i]) if (q[i].rid == aid) q[i].live = 1'b0;
      m_we = 1'b1; m_wd = ad; m_wid = aid;
    end else if (nonempty) begin
      e = q.pop_front();
      m_we = e.live;
      if (e.live) begin m_wd = e.d; m_wid = e.rid; end
    end else begin
      m_we = 1'b0;
    end
    if (acc && (mid != 5'd0)) q.push_back('{live: !(win && (aid == mid)), rid: mid, d: md});
    if (win && head_live) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
    else if (pop || !nonempty) m_starve = 0;
    if (m_hold) m_hold = !m_popped_last;
    else        m_hold = (m_starve >= LIM);
    m_popped_last = pop;
  endtask

  // Drive one cycle of inputs; returns just after the following falling edge.
  task automatic step(input bit nrst, input bit av, input bit [4:0] aid, input bit [31:0] ad,
                      input bit mv, input bit [4:0] mid, input bit [31:0] md);
    NReset = nrst; AluValid = av; AluRegID = aid; AluData = ad;
    MemValid = mv; MemRegID = mid; MemData = md;
    model_edge(nrst, av, aid, ad, mv, mid, md);
    chk_en = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge Clock) begin
    bit [31:0] mask;
    #2;
    if (chk_en) begin
      mask = 32'd0;
      foreach (q[i]) if (q[i].live) mask = mask | (32'd1 << q[i].rid);
      chk("we",    {31'd0, WriteEnable}, {31'd0, m_we});
      if (m_we || !NReset) begin
        chk("wdata", WriteData, m_wd);
        chk("wid",   {27'd0, WriteRegID}, {27'd0, m_wid});
      end
      chk("hold",  {31'd0, AluHold}, {31'd0, m_hold});
      chk("mask",  PendingMask, mask);
      chk("count", {29'd0, FifoCount}, q.size());
      chk("ready", {31'd0, MemReady}, {31'd0, (q.size() < DEPTH)});
      if (WriteEnable === 1'b1) shadow[WriteRegID] = WriteData;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    NReset = 1'b0; AluValid = 1'b0; AluRegID = 5'd0; AluData = 32'd0;
    MemValid = 1'b0; MemRegID = 5'd0; MemData = 32'd0;

    // Reset then idle
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle();
    chk("rst_we",    {31'd0, WriteEnable}, 32'd0);
    chk("rst_data",  WriteData, 32'd0);
    chk("rst_ready", {31'd0, MemReady}, 32'd1);
    chk("rst_count", {29'd0, FifoCount}, 32'd0);

    // ALU only
    step(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    chk("alu_we",   {31'd0, WriteEnable}, 32'd1);
    chk("alu_id",   {27'd0, WriteRegID}, 32'd5);
    chk("alu_data", WriteData, 32'h1234_5678);
    step(1'b1, 1'b1, 5'd0, 32'h0000_0055, 1'b0, 5'd0, 32'd0);
    chk("alu_r0_we",   {31'd0, WriteEnable}, 32'd0);
    chk("alu_r0_hold", WriteData, 32'h1234_5678);

    // Fill FIFO behind continuous ALU writes to reg 9
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b1, 5'd9, 32'h0000_0900 + i, 1'b1, 5'(i), 32'h0000_00A0 + i);
    chk("full_ready", {31'd0, MemReady}, 32'd0);
    chk("full_mask",  PendingMask, 32'h0000_001E);
    chk("full_count", {29'd0, FifoCount}, 32'd4);
    // Offer while full: must not be accepted
    step(1'b1, 1'b1, 5'd9, 32'h0000_0999, 1'b1, 5'd20, 32'h0000_0BAD);
    chk("full_nopush", {29'd0, FifoCount}, 32'd4);
    chk("full_mask2",  PendingMask, 32'h0000_001E);
    // Drain in order
    for (int i = 1; i <= 4; i++) begin
      idle();
      chk("drain_we",   {31'd0, WriteEnable}, 32'd1);
      chk("drain_id",   {27'd0, WriteRegID}, i);
      chk("drain_data", WriteData, 32'h0000_00A0 + i);
    end
    idle();
    chk("drain_done", {31'd0, WriteEnable}, 32'd0);
    idle();

    // WAW kill of an older buffered load
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_DEAD);
    chk("waw_pend", PendingMask, 32'h0000_0080);
    step(1'b1, 1'b1, 5'd7, 32'h0000_BEEF, 1'b0, 5'd0, 32'd0);
    chk("waw_mask",  PendingMask, 32'd0);
    chk("waw_count", {29'd0, FifoCount}, 32'd1);
    idle();
    chk("waw_pop_we", {31'd0, WriteEnable}, 32'd0);
    chk("waw_empty",  {29'd0, FifoCount}, 32'd0);
    chk("waw_reg7",   shadow[7], 32'h0000_BEEF);

    // Load accepted in the same edge as a matching ALU write enters killed
    step(1'b1, 1'b1, 5'd8, 32'h0000_0808, 1'b1, 5'd8, 32'h0000_0888);
    chk("same_kill_mask",  PendingMask, 32'd0);
    chk("same_kill_count", {29'd0, FifoCount}, 32'd1);
    idle();
    chk("same_kill_pop", {31'd0, WriteEnable}, 32'd0);
    chk("reg8",          shadow[8], 32'h0000_0808);

    // Push and pop in the same edge
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h0000_0010);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h0000_0011);
    chk("pp_count", {29'd0, FifoCount}, 32'd1);
    chk("pp_id",    {27'd0, WriteRegID}, 32'd10);
    idle();
    chk("pp_id2",   {27'd0, WriteRegID}, 32'd11);
    idle();

    // Starvation
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h0000_00C0);
    step(1'b1, 1'b1, 5'd3, 32'h0000_0301, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b1, 5'd3, 32'h0000_0302, 1'b0, 5'd0, 32'd0);
    chk("starve_2", {31'd0, AluHold}, 32'd0);
    step(1'b1, 1'b1, 5'd3, 32'h0000_0303, 1'b0, 5'd0, 32'd0);
    chk("starve_3", {31'd0, AluHold}, 32'd1);
    idle();
    chk("starve_pop_id", {27'd0, WriteRegID}, 32'd12);
    chk("starve_hold1",  {31'd0, AluHold}, 32'd1);
    idle();
    chk("starve_hold0",  {31'd0, AluHold}, 32'd0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 5'd3, 32'h0000_0310 + i, 1'b1, 5'(13 + i), 32'h0000_0D00 + i);
    step(1'b1, 1'b1, 5'd3, 32'h0000_0320, 1'b0, 5'd0, 32'd0);
    chk("mid_hold",  {31'd0, AluHold}, 32'd1);
    chk("mid_count", {29'd0, FifoCount}, 32'd3);
    step(1'b0, 1'b1, 5'd4, 32'h0000_0444, 1'b1, 5'd16, 32'h0000_0DDD);
    chk("mid_rst_count", {29'd0, FifoCount}, 32'd0);
    chk("mid_rst_mask",  PendingMask, 32'd0);
    chk("mid_rst_hold",  {31'd0, AluHold}, 32'd0);
    chk("mid_rst_we",    {31'd0, WriteEnable}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("mid_no_write", {31'd0, WriteEnable}, 32'd0);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
